// File: rtl/alu_arbiter_ctrl.sv
// Two-requester front end for a registered ALU: arbitrates, issues operands, captures and holds results.
// Optional build macro ALU_CTRL_FIXED_PRIO_EN gives requester 0 fixed priority instead of round-robin.
module alu_arbiter_ctrl #(
  parameter int Op_Width = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req0_valid,
  input  logic [Op_Width-1:0] req0_a,
  input  logic [Op_Width-1:0] req0_b,
  input  logic [3:0]          req0_fun,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [Op_Width-1:0] req1_a,
  input  logic [Op_Width-1:0] req1_b,
  input  logic [3:0]          req1_fun,
  output logic                req1_ready,
  output logic                rsp0_valid,
  output logic [Op_Width-1:0] rsp0_result,
  output logic                rsp0_carry,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  output logic [Op_Width-1:0] rsp1_result,
  output logic                rsp1_carry,
  input  logic                rsp1_ready,
  output logic [Op_Width-1:0] alu_a,
  output logic [Op_Width-1:0] alu_b,
  output logic [3:0]          alu_fun,
  input  logic [Op_Width-1:0] arith_out,
  input  logic [Op_Width-1:0] logic_out,
  input  logic [Op_Width-1:0] cmp_out,
  input  logic [Op_Width-1:0] shift_out,
  input  logic                carry_out,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  localparam logic [3:0] FUN_NOP = 4'b1000;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_grant_id;
  logic                w_grant_en;
  logic                w_grant_id;
  logic                w_rsp_ack;
  logic [Op_Width-1:0] r_alu_a;
  logic [Op_Width-1:0] r_alu_b;
  logic [3:0]          r_alu_fun;
  logic                r_rsp0_valid;
  logic [Op_Width-1:0] r_rsp0_result;
  logic                r_rsp0_carry;
  logic                r_rsp1_valid;
  logic [Op_Width-1:0] r_rsp1_result;
  logic                r_rsp1_carry;
  logic [Op_Width-1:0] w_sel_result;
  logic                w_sel_carry;
`ifndef ALU_CTRL_FIXED_PRIO_EN
  logic                r_last_grant;
`endif

  function automatic logic [Op_Width-1:0] f_sel_result(
    input logic [1:0]          unit,
    input logic [Op_Width-1:0] ar,
    input logic [Op_Width-1:0] lo,
    input logic [Op_Width-1:0] cm,
    input logic [Op_Width-1:0] sh
  );
    case (unit)
      2'b00:   return ar;
      2'b01:   return lo;
      2'b10:   return cm;
      default: return sh;
    endcase
  endfunction

  // Only the arithmetic unit produces a meaningful carry.
  function automatic logic f_mask_carry(input logic [1:0] unit, input logic c);
    return (unit == 2'b00) && c;
  endfunction

  always_comb begin
    w_grant_en = (r_state == IDLE) && !RST && (req0_valid || req1_valid);
`ifdef ALU_CTRL_FIXED_PRIO_EN
    w_grant_id = !req0_valid;
`else
    w_grant_id = (req0_valid && req1_valid) ? !r_last_grant : !req0_valid;
`endif
    w_rsp_ack    = r_grant_id ? rsp1_ready : rsp0_ready;
    w_sel_result = f_sel_result(r_alu_fun[3:2], arith_out, logic_out, cmp_out, shift_out);
    w_sel_carry  = f_mask_carry(r_alu_fun[3:2], carry_out);
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_en) begin
          w_state_nxt = EXEC;
          req0_ready  = !w_grant_id;
          req1_ready  = w_grant_id;
        end
      end
      EXEC:    w_state_nxt = CAPT;
      CAPT:    w_state_nxt = RESP;
      RESP:    if (w_rsp_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant_id    <= 1'b0;
`ifndef ALU_CTRL_FIXED_PRIO_EN
      r_last_grant  <= 1'b1;
`endif
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_fun     <= FUN_NOP;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_carry  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_carry  <= 1'b0;
    end else begin
      // Issue stage: latch the winner's command onto the ALU inputs.
      if (w_grant_en) begin
        r_grant_id   <= w_grant_id;
`ifndef ALU_CTRL_FIXED_PRIO_EN
        r_last_grant <= w_grant_id;
`endif
        r_alu_a      <= w_grant_id ? req1_a   : req0_a;
        r_alu_b      <= w_grant_id ? req1_b   : req0_b;
        r_alu_fun    <= w_grant_id ? req1_fun : req0_fun;
      end else if ((r_state == IDLE) || ((r_state == RESP) && w_rsp_ack)) begin
        r_alu_fun    <= FUN_NOP;
      end
      // Capture stage: only the granted requester's response registers move.
      if (r_state == CAPT) begin
        if (r_grant_id) begin
          r_rsp1_valid  <= 1'b1;
          r_rsp1_result <= w_sel_result;
          r_rsp1_carry  <= w_sel_carry;
        end else begin
          r_rsp0_valid  <= 1'b1;
          r_rsp0_result <= w_sel_result;
          r_rsp0_carry  <= w_sel_carry;
        end
      end
      // Response stage: hold until the owner consumes it.
      if ((r_state == RESP) && w_rsp_ack) begin
        if (r_grant_id) r_rsp1_valid <= 1'b0;
        else            r_rsp0_valid <= 1'b0;
      end
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_fun     = r_alu_fun;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_carry  = r_rsp0_carry;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_carry  = r_rsp1_carry;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: a registered ALU model plus a transaction-level reference of arbitration and results.
module tb_alu_arbiter_ctrl;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   req0_fun = '0, req1_fun = '0;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid, rsp0_carry, rsp1_carry;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_fun;
  logic [W-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic         carry_out = 1'b0;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int           m_last;
  logic [W-1:0] m_res [2];
  logic         m_car [2];

  always #5 CLK = ~CLK;

  alu_arbiter_ctrl #(.Op_Width(W)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_carry(rsp0_carry), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_carry(rsp1_carry), .rsp1_ready(rsp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .carry_out(carry_out), .busy(busy)
  );

  function automatic logic [W:0] f_arith(input logic [W-1:0] a, b, input logic [3:0] fun);
    return fun[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction
  function automatic logic [W-1:0] f_logic(input logic [W-1:0] a, b, input logic [3:0] fun);
    case (fun[1:0])
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction
  function automatic logic [W-1:0] f_cmp(input logic [W-1:0] a, b, input logic [3:0] fun);
    return fun[0] ? W'(a == b) : W'(a < b);
  endfunction
  function automatic logic [W-1:0] f_shift(input logic [W-1:0] a, input logic [3:0] fun);
    return fun[0] ? (a << 1) : (a >> 1);
  endfunction

  // Registered ALU: every unit computes in parallel; carry is forced high outside arithmetic.
  always @(posedge CLK) begin : alu_model
    logic [W:0] t;
    t = f_arith(alu_a, alu_b, alu_fun);
    arith_out <= t[W-1:0];
    logic_out <= f_logic(alu_a, alu_b, alu_fun);
    cmp_out   <= f_cmp(alu_a, alu_b, alu_fun);
    shift_out <= f_shift(alu_a, alu_fun);
    carry_out <= (alu_fun[3:2] == 2'b00) ? t[W] : 1'b1;
  end

  // Expected {carry, result} delivered to the requester for one command.
  function automatic logic [W:0] exp_rsp(input logic [W-1:0] a, b, input logic [3:0] fun);
    case (fun[3:2])
      2'b00:   return f_arith(a, b, fun);
      2'b01:   return {1'b0, f_logic(a, b, fun)};
      2'b10:   return {1'b0, f_cmp(a, b, fun)};
      default: return {1'b0, f_shift(a, fun)};
    endcase
  endfunction

  function automatic int exp_grant(input logic v0, v1);
    if (v0 && v1) begin
`ifdef ALU_CTRL_FIXED_PRIO_EN
      return 0;
`else
      return (m_last == 0) ? 1 : 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    m_last = 1;
    m_res[0] = '0; m_res[1] = '0;
    m_car[0] = 1'b0; m_car[1] = 1'b0;
  endtask

  // Drives one transaction from a negedge and reports what the DUT did; callers compare.
  task automatic run_one(input logic v0, v1,
                         input logic [W-1:0] a0, b0, input logic [3:0] f0,
                         input logic [W-1:0] a1, b1, input logic [3:0] f1,
                         input int hold, input bit poke,
                         output int g, output int lat, output logic [W-1:0] res, output logic car,
                         output bit stable, output int stray, output bit busy_ok,
                         output logic post_v, output logic post_b);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_fun = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_fun = f1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    g = -1; lat = 0; res = '0; car = 1'b0; stable = 1'b1; stray = 0; busy_ok = 1'b1;
    post_v = 1'b1; post_b = 1'b1;
    for (int n = 0; n < 20 && g < 0; n++) begin
      #1;
      if (req0_ready && req1_ready) g = 2;
      else if (req0_ready) g = 0;
      else if (req1_ready) g = 1;
      @(negedge CLK);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (g < 0 || g > 1) return;
    lat = 1;
    while (!((g == 0) ? rsp0_valid : rsp1_valid) && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge CLK);
      lat++;
    end
    res = (g == 0) ? rsp0_result : rsp1_result;
    car = (g == 0) ? rsp0_carry  : rsp1_carry;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        if (req0_ready || req1_ready) stray++;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge CLK);
      if (!((g == 0) ? rsp0_valid : rsp1_valid) || res !== ((g == 0) ? rsp0_result : rsp1_result) ||
          car !== ((g == 0) ? rsp0_carry : rsp1_carry))
        stable = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!busy) busy_ok = 1'b0;
    if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge CLK);
    post_v = (g == 0) ? rsp0_valid : rsp1_valid;
    post_b = busy;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*W+4+2*W+8-1:0] obs, exp;
    @(negedge CLK);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready_dominated: got %b want 00", {req0_ready, req1_ready});
    end
    obs = {alu_a, alu_b, alu_fun, rsp0_result, rsp1_result, rsp0_valid, rsp1_valid, rsp0_carry, rsp1_carry,
           busy, 3'b000};
    exp = {{W{1'b0}}, {W{1'b0}}, 4'b1000, {W{1'b0}}, {W{1'b0}}, 8'h00};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", obs, exp);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    m_last = 1;
    m_res[0] = '0; m_res[1] = '0; m_car[0] = 1'b0; m_car[1] = 1'b0;
  endtask

  task automatic test_add();
    int g, lat, stray; logic [W-1:0] res; logic car, pv, pb; bit st, bo;
    run_one(1'b1, 1'b0, 16'd4, 16'd2, 4'b0000, '0, '0, 4'b0000, 0, 1'b0,
            g, lat, res, car, st, stray, bo, pv, pb);
    n_tests++;
    if (g !== 0 || lat !== 3) begin
      n_fail++;
      $display("FAIL add_grant_latency: got grant %0d lat %0d want grant 0 lat 3", g, lat);
    end
    n_tests++;
    if (res !== 16'd6 || car !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: got %h/%b want 0006/0", res, car);
    end
    n_tests++;
    if (!bo || pv !== 1'b0 || pb !== 1'b0 || alu_fun !== 4'b1000) begin
      n_fail++;
      $display("FAIL add_busy_release: got busy_ok %0d post_valid %b post_busy %b alu_fun %b want 1 0 0 1000",
               bo, pv, pb, alu_fun);
    end
    m_res[0] = 16'd6; m_car[0] = 1'b0; m_last = 0;
  endtask

  task automatic test_contention();
    int g, eg, lat, stray; logic [W-1:0] res; logic car, pv, pb; bit st, bo;
    logic [W:0] e;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      eg = exp_grant(1'b1, 1'b1);
      run_one(1'b1, 1'b1, 16'hAAAA, 16'hCCCC, 4'b0100, 16'hAAAA, 16'hCCCC, 4'b0101, 0, 1'b0,
              g, lat, res, car, st, stray, bo, pv, pb);
      e = exp_rsp(16'hAAAA, 16'hCCCC, (eg == 0) ? 4'b0100 : 4'b0101);
      n_tests++;
      if (g !== eg || (k == 0 && g !== 0)) begin
        n_fail++;
        $display("FAIL contention_grant_%0d: got %0d want %0d", k, g, eg);
      end
      n_tests++;
      if (res !== e[W-1:0] || car !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_result_%0d: got %h want %h", k, res, e[W-1:0]);
      end
      if (eg >= 0 && eg <= 1) begin m_res[eg] = e[W-1:0]; m_car[eg] = e[W]; m_last = eg; end
    end
    n_tests++;
    if (rsp0_result !== 16'h8888) begin
      n_fail++;
      $display("FAIL contention_rsp0: got %h want 8888", rsp0_result);
    end
  endtask

  task automatic test_backpressure();
    int g, lat, stray; logic [W-1:0] res; logic car, pv, pb; bit st, bo;
    run_one(1'b0, 1'b1, '0, '0, 4'b0000, 16'h7AF3, 16'h0000, 4'b1101, 5, 1'b1,
            g, lat, res, car, st, stray, bo, pv, pb);
    n_tests++;
    if (g !== 1 || lat !== 3 || res !== 16'hF5E6 || car !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_result: got g%0d lat%0d %h/%b want g1 lat3 F5E6/0", g, lat, res, car);
    end
    n_tests++;
    if (!st || stray !== 0 || !bo || pv !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_hold: got stable %0d stray %0d busy_ok %0d post_valid %b want 1 0 1 0",
               st, stray, bo, pv);
    end
    m_res[1] = 16'hF5E6; m_car[1] = 1'b0; m_last = 1;
  endtask

  task automatic test_carry_mask();
    int g, lat, stray; logic [W-1:0] res; logic car, pv, pb; bit st, bo;
    run_one(1'b1, 1'b0, 16'd0, 16'd1, 4'b0001, '0, '0, 4'b0000, 0, 1'b0,
            g, lat, res, car, st, stray, bo, pv, pb);
    n_tests++;
    if (g !== 0 || res !== 16'hFFFF || car !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_sub: got g%0d %h/%b want g0 FFFF/1", g, res, car);
    end
    run_one(1'b0, 1'b1, '0, '0, 4'b0000, 16'd5, 16'd5, 4'b1001, 0, 1'b0,
            g, lat, res, car, st, stray, bo, pv, pb);
    n_tests++;
    if (g !== 1 || res !== 16'h0001 || car !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_cmp_masked: got g%0d %h/%b want g1 0001/0", g, res, car);
    end
    m_res[0] = 16'hFFFF; m_car[0] = 1'b1; m_res[1] = 16'h0001; m_car[1] = 1'b0; m_last = 1;
  endtask

  task automatic test_reset_midop();
    int seen;
    logic [2*W+4+2*W+5-1:0] obs;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_fun = 4'b0000;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_accept: got %b want 1", req0_ready);
    end
    @(negedge CLK);
    req0_valid = 1'b0;
    RST = 1'b1;
    rsp0_ready = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    rsp0_ready = 1'b0;
    obs = {alu_a, alu_b, alu_fun, rsp0_result, rsp1_result, rsp0_valid, rsp1_valid, rsp0_carry, rsp1_carry, busy};
    n_tests++;
    if (obs !== {{W{1'b0}}, {W{1'b0}}, 4'b1000, {W{1'b0}}, {W{1'b0}}, 5'b00000}) begin
      n_fail++;
      $display("FAIL midop_reset_values: got %h want all zero with alu_fun 1000", obs);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rsp0_valid || rsp1_valid || busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midop_no_response: got %0d active cycles want 0", seen);
    end
    m_last = 1;
    m_res[0] = '0; m_res[1] = '0; m_car[0] = 1'b0; m_car[1] = 1'b0;
  endtask

  task automatic test_random();
    int g, eg, lat, stray, r, hold; logic [W-1:0] res; logic car, pv, pb; bit st, bo, poke;
    logic v0, v1; logic [W-1:0] a0, b0, a1, b1; logic [3:0] f0, f1; logic [W:0] e;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(1, 3);
      v0 = r[0]; v1 = r[1];
      a0 = W'($urandom); b0 = W'($urandom); f0 = 4'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); f1 = 4'($urandom);
      hold = $urandom_range(0, 3);
      poke = 1'($urandom);
      eg = exp_grant(v0, v1);
      e = (eg == 0) ? exp_rsp(a0, b0, f0) : exp_rsp(a1, b1, f1);
      run_one(v0, v1, a0, b0, f0, a1, b1, f1, hold, poke, g, lat, res, car, st, stray, bo, pv, pb);
      n_tests++;
      if (g !== eg || lat !== 3) begin
        n_fail++;
        $display("FAIL rand%0d_grant: got g%0d lat%0d want g%0d lat3", t, g, lat, eg);
      end
      n_tests++;
      if (res !== e[W-1:0] || car !== e[W]) begin
        n_fail++;
        $display("FAIL rand%0d_result: got %h/%b want %h/%b", t, res, car, e[W-1:0], e[W]);
      end
      n_tests++;
      if (!st || stray !== 0 || !bo || pv !== 1'b0 || pb !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_handshake: got st%0d stray%0d bo%0d pv%b pb%b want 1 0 1 0 0",
                 t, st, stray, bo, pv, pb);
      end
      m_res[eg] = e[W-1:0]; m_car[eg] = e[W]; m_last = eg;
      n_tests++;
      if (rsp0_result !== m_res[0] || rsp0_carry !== m_car[0] ||
          rsp1_result !== m_res[1] || rsp1_carry !== m_car[1]) begin
        n_fail++;
        $display("FAIL rand%0d_held_outputs: got %h/%b %h/%b want %h/%b %h/%b", t,
                 rsp0_result, rsp0_carry, rsp1_result, rsp1_carry, m_res[0], m_car[0], m_res[1], m_car[1]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_contention();
    test_backpressure();
    test_carry_mask();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
